// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC measurement path. The thermometer decoders
// and the sequencer both take their bin width from here so that a decoded
// start/stop bin number always has the same width on both sides.
//
// Contents:
//   tdc_seq_state_t     sequencer state encoding (IDLE, ARMED, RUN, DONE)
//   TDC_BITS_DECO       default width of a decoded bin number
//   TDC_COARSE_BITS     default width of the coarse clock-cycle counter
//   TDC_TIMEOUT_CYCLES  default RUN length before a measurement is abandoned
// -----------------------------------------------------------------------------
package tdc_pkg;

  localparam int TDC_BITS_DECO      = 8;
  localparam int TDC_COARSE_BITS    = 16;
  localparam int TDC_TIMEOUT_CYCLES = 4095;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } tdc_seq_state_t;

endpackage : tdc_pkg

// File: rtl/tdc_coarse_counter.sv
// -----------------------------------------------------------------------------
// tdc_coarse_counter
// Coarse clock-cycle counter for one TDC measurement. The count is held
// unless enabled. A clear restarts the count at zero; when clear and enable
// are both high in the same cycle, that cycle is counted as the zeroth, so
// the counter already reads 1 on the following cycle. This makes the count
// in cycle c equal to (c - start cycle) while the sequencer is in RUN.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset (count -> 0)
//   clear_i     restart the count at zero
//   enable_i    advance the count by one
//   count_o     current count
//   terminal_o  count equals TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module tdc_coarse_counter #(
  parameter int COUNT_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  output logic [COUNT_BITS-1:0] count_o,
  output logic                  terminal_o
);

  localparam logic [COUNT_BITS-1:0] TERMINAL_COUNT = COUNT_BITS'(TIMEOUT_CYCLES);

  logic [COUNT_BITS-1:0] count_q;
  logic [COUNT_BITS-1:0] count_d;
  logic [COUNT_BITS-1:0] count_base;

  // Clear is applied before the increment so clear+enable yields 1.
  always_comb begin
    count_base = clear_i ? '0 : count_q;
    count_d    = enable_i ? (count_base + COUNT_BITS'(1)) : count_base;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == TERMINAL_COUNT);

endmodule : tdc_coarse_counter

// File: rtl/tdc_measure_sequencer.sv
// -----------------------------------------------------------------------------
// tdc_measure_sequencer
// Sequences one time-interval measurement: waits for an arm request, detects
// the start edge and then the stop edge from the decoded bin numbers (zero
// means no edge), counts whole clock cycles in between and offers
// {coarse, start bin, stop bin, timeout} as one registered result word with a
// valid/ready handshake. In continuous mode it re-arms after each handshake.
// Start edges that arrive while a result is waiting are counted in a
// saturating missed-hit counter that only reset clears.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   arm_i            single-cycle request to start a measurement
//   abort_i          cancel any measurement in progress or pending
//   continuous_i     re-arm automatically after each result handshake
//   start_bin_i      decoded start-channel bin, 0 = no edge
//   stop_bin_i       decoded stop-channel bin, 0 = no edge
//   res_valid_o      result word valid
//   res_ready_i      consumer accepts the result
//   res_coarse_o     clock cycles from start edge to stop edge
//   res_start_bin_o  latched start bin
//   res_stop_bin_o   latched stop bin, 0 on timeout
//   res_timeout_o    no stop arrived within TIMEOUT_CYCLES
//   busy_o           sequencer not idle
//   missed_hits_o    saturating count of start edges seen while in DONE
// -----------------------------------------------------------------------------
module tdc_measure_sequencer
  import tdc_pkg::*;
#(
  parameter int BITS_DECO      = TDC_BITS_DECO,
  parameter int COARSE_BITS    = TDC_COARSE_BITS,
  parameter int TIMEOUT_CYCLES = TDC_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic                   continuous_i,
  input  logic [BITS_DECO-1:0]   start_bin_i,
  input  logic [BITS_DECO-1:0]   stop_bin_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [COARSE_BITS-1:0] res_coarse_o,
  output logic [BITS_DECO-1:0]   res_start_bin_o,
  output logic [BITS_DECO-1:0]   res_stop_bin_o,
  output logic                   res_timeout_o,
  output logic                   busy_o,
  output logic [7:0]             missed_hits_o
);

  tdc_seq_state_t state_q, state_d;

  logic [COARSE_BITS-1:0] res_coarse_q, res_coarse_d;
  logic [BITS_DECO-1:0]   res_start_bin_q, res_start_bin_d;
  logic [BITS_DECO-1:0]   res_stop_bin_q, res_stop_bin_d;
  logic                   res_timeout_q, res_timeout_d;
  logic [7:0]             missed_hits_q, missed_hits_d;

  logic                   start_hit;
  logic                   stop_hit;
  logic                   counter_clear;
  logic                   counter_enable;
  logic [COARSE_BITS-1:0] coarse_count;
  logic                   coarse_terminal;

  assign start_hit = |start_bin_i;
  assign stop_hit  = |stop_bin_i;

  tdc_coarse_counter #(
    .COUNT_BITS     (COARSE_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_coarse_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (counter_clear),
    .enable_i   (counter_enable),
    .count_o    (coarse_count),
    .terminal_o (coarse_terminal)
  );

  // Next-state and result-capture logic. Abort overrides every other input
  // and discards whatever result was being built or waiting.
  always_comb begin
    state_d         = state_q;
    res_coarse_d    = res_coarse_q;
    res_start_bin_d = res_start_bin_q;
    res_stop_bin_d  = res_stop_bin_q;
    res_timeout_d   = res_timeout_q;
    missed_hits_d   = missed_hits_q;
    counter_clear   = 1'b0;
    counter_enable  = 1'b0;

    if (abort_i) begin
      state_d         = IDLE;
      res_coarse_d    = '0;
      res_start_bin_d = '0;
      res_stop_bin_d  = '0;
      res_timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d = ARMED;
          end
        end

        ARMED: begin
          // A lone stop edge has no start to refer to and is dropped.
          if (start_hit) begin
            res_start_bin_d = start_bin_i;
            res_coarse_d    = '0;
            res_timeout_d   = 1'b0;
            if (stop_hit) begin
              res_stop_bin_d = stop_bin_i;
              state_d        = DONE;
            end else begin
              res_stop_bin_d = '0;
              counter_clear  = 1'b1;
              counter_enable = 1'b1;
              state_d        = RUN;
            end
          end
        end

        RUN: begin
          // A stop in the terminal cycle still counts as a real stop.
          if (stop_hit) begin
            res_stop_bin_d = stop_bin_i;
            res_coarse_d   = coarse_count;
            res_timeout_d  = 1'b0;
            state_d        = DONE;
          end else if (coarse_terminal) begin
            res_stop_bin_d = '0;
            res_coarse_d   = coarse_count;
            res_timeout_d  = 1'b1;
            state_d        = DONE;
          end else begin
            counter_enable = 1'b1;
          end
        end

        DONE: begin
          if (start_hit && (missed_hits_q != 8'hFF)) begin
            missed_hits_d = missed_hits_q + 8'd1;
          end
          if (res_ready_i) begin
            state_d = continuous_i ? ARMED : IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      res_coarse_q    <= '0;
      res_start_bin_q <= '0;
      res_stop_bin_q  <= '0;
      res_timeout_q   <= 1'b0;
      missed_hits_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      res_coarse_q    <= res_coarse_d;
      res_start_bin_q <= res_start_bin_d;
      res_stop_bin_q  <= res_stop_bin_d;
      res_timeout_q   <= res_timeout_d;
      missed_hits_q   <= missed_hits_d;
    end
  end

  // Every output comes straight from a register.
  assign res_valid_o     = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);
  assign res_coarse_o    = res_coarse_q;
  assign res_start_bin_o = res_start_bin_q;
  assign res_stop_bin_o  = res_stop_bin_q;
  assign res_timeout_o   = res_timeout_q;
  assign missed_hits_o   = missed_hits_q;

endmodule : tdc_measure_sequencer

// File: tb/tb_tdc_measure_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tdc_measure_sequencer
// Directed bench for the measurement sequencer, built with a short timeout
// (8 cycles) so timeout behaviour is reached quickly. Inputs change 1 time
// unit after the rising edge; outputs are inspected at the same point, i.e.
// they show the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_tdc_measure_sequencer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        continuous;
  logic [7:0]  start_bin;
  logic [7:0]  stop_bin;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_coarse;
  logic [7:0]  res_start_bin;
  logic [7:0]  res_stop_bin;
  logic        res_timeout;
  logic        busy;
  logic [7:0]  missed_hits;

  int checkCount = 0;
  int errorCount = 0;

  tdc_measure_sequencer #(
    .BITS_DECO      (8),
    .COARSE_BITS    (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .arm_i           (arm),
    .abort_i         (abort),
    .continuous_i    (continuous),
    .start_bin_i     (start_bin),
    .stop_bin_i      (stop_bin),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_coarse_o    (res_coarse),
    .res_start_bin_o (res_start_bin),
    .res_stop_bin_o  (res_stop_bin),
    .res_timeout_o   (res_timeout),
    .busy_o          (busy),
    .missed_hits_o   (missed_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, take the edge, settle just after it.
  task automatic applyStimulus(input logic a, input logic ab, input logic c,
                               input logic r, input logic [7:0] sb,
                               input logic [7:0] pb);
    arm        = a;
    abort      = ab;
    continuous = c;
    res_ready  = r;
    start_bin  = sb;
    stop_bin   = pb;
    @(posedge clk);
    #1;
  endtask

  // The single comparison point of the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic v, input logic [15:0] co,
                             input logic [7:0] sb, input logic [7:0] pb,
                             input logic to);
    checkOutput({tag, "_valid"},   64'(res_valid),     64'(v));
    checkOutput({tag, "_coarse"},  64'(res_coarse),    64'(co));
    checkOutput({tag, "_startbin"}, 64'(res_start_bin), 64'(sb));
    checkOutput({tag, "_stopbin"}, 64'(res_stop_bin),  64'(pb));
    checkOutput({tag, "_timeout"}, 64'(res_timeout),   64'(to));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    checkResult("reset", 1'b0, 16'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_missed", 64'(missed_hits), 64'd0);

    // Stop edge while idle is ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd33);
    checkOutput("idle_stop_busy", 64'(busy), 64'd0);

    // Basic measurement: start 17, stop 42 five cycles later.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("arm_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd17, 8'd0);
    idle(4);
    checkOutput("run_valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd42);
    checkResult("basic", 1'b1, 16'd5, 8'd17, 8'd42, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    checkOutput("basic_hs_valid", 64'(res_valid), 64'd0);
    checkOutput("basic_hs_busy", 64'(busy), 64'd0);

    // Timeout: start and no stop for 8 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0);
    idle(7);
    checkOutput("tmo_pre_valid", 64'(res_valid), 64'd0);
    idle(1);
    checkResult("timeout", 1'b1, 16'd8, 8'd5, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

    // Stop exactly in the terminal cycle wins over the timeout.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0);
    idle(7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd11);
    checkResult("edge_stop", 1'b1, 16'd8, 8'd5, 8'd11, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

    // Stop-only cycle in ARMED is ignored, then start+stop together.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd9);
    checkOutput("armed_stop_busy", 64'(busy), 64'd1);
    checkOutput("armed_stop_valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd9);
    checkResult("same_cycle", 1'b1, 16'd0, 8'd3, 8'd9, 1'b0);

    // Hold the result for 10 cycles with start hits and an ignored arm.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 4), 1'b0, 1'b0, 1'b0,
                    ((i == 2) || (i == 5) || (i == 8)) ? 8'd50 : 8'd0, 8'd0);
      checkOutput("hold_word",
                  64'({res_valid, res_coarse, res_start_bin, res_stop_bin, res_timeout}),
                  64'({1'b1, 16'd0, 8'd3, 8'd9, 1'b0}));
    end
    checkOutput("missed_hits", 64'(missed_hits), 64'd3);

    // Continuous handshake re-arms; a start right after is accepted.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
    checkOutput("cont_valid", 64'(res_valid), 64'd0);
    checkOutput("cont_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd20, 8'd0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd30);
    checkResult("cont_meas", 1'b1, 16'd2, 8'd20, 8'd30, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    checkOutput("cont_end_busy", 64'(busy), 64'd0);

    // Abort during RUN, then a clean measurement.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'd0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    checkOutput("abort_run_busy", 64'(busy), 64'd0);
    checkOutput("abort_run_valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd8, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd9);
    checkResult("after_abort_run", 1'b1, 16'd1, 8'd8, 8'd9, 1'b0);

    // Abort during DONE (with ready high, abort still wins).
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0);
    checkOutput("abort_done_busy", 64'(busy), 64'd0);
    checkOutput("abort_done_valid", 64'(res_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd6);
    checkResult("after_abort_done", 1'b1, 16'd2, 8'd4, 8'd6, 1'b0);
    checkOutput("missed_kept", 64'(missed_hits), 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);

    // Reset in the middle of RUN clears everything.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd10, 8'd0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkResult("mid_reset", 1'b0, 16'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("mid_reset_busy", 64'(busy), 64'd0);
    checkOutput("mid_reset_missed", 64'(missed_hits), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_tdc_measure_sequencer

// File: doc/tdc_measure_sequencer.md
# tdc_measure_sequencer

Sequences one time-interval measurement of the TDC: arms the start and stop delay-line channels, detects the start and stop edges from the decoded bin numbers, and runs a coarse clock-cycle counter between them. It presents {coarse count, start bin, stop bin, timeout} as one result word through a valid/ready handshake. It sits between the two per-channel thermometer decoders and the readout/histogram logic.

## Interface
- `BITS_DECO`, default 8: width of the decoded start/stop bin numbers.
- `COARSE_BITS`, default 16: width of the coarse counter; must satisfy `TIMEOUT_CYCLES < 2**COARSE_BITS`.
- `TIMEOUT_CYCLES`, default 4095: the number of RUN cycles without a stop before the measurement is abandoned.
- `clk`  in  1  single system clock; all logic rises on it.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle request to start a measurement.
- `abort`  in  1  cancels any measurement in progress or pending.
- `continuous`  in  1  when 1, re-arm automatically after each result handshake.
- `start_bin`  in  BITS_DECO  decoded start-channel bin; 0 means no edge this cycle.
- `stop_bin`  in  BITS_DECO  decoded stop-channel bin; 0 means no edge this cycle.
- `res_valid`  out  1  result word is valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_coarse`  out  COARSE_BITS  clock cycles from the start edge to the stop edge.
- `res_start_bin`  out  BITS_DECO  latched start bin.
- `res_stop_bin`  out  BITS_DECO  latched stop bin; 0 on timeout.
- `res_timeout`  out  1  no stop arrived within `TIMEOUT_CYCLES`.
- `busy`  out  1  state is not IDLE.
- `missed_hits`  out  8  saturating count of start edges seen while in DONE; cleared on reset only.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset → IDLE, and all outputs are 0.
- A cycle has a start hit when `start_bin != 0`. It has a stop hit when `stop_bin != 0`.
- **IDLE:** `arm` → ARMED. Stop hits are ignored here.
- **ARMED:**
  - A stop hit without a start hit is ignored.
  - A start hit alone latches `start_bin`, clears the coarse counter to 0 and moves to RUN.
  - A start hit and a stop hit in the same cycle latch both bins, set `res_coarse` to 0 and move directly to DONE.
- **RUN:**
  - The coarse counter increments by 1 each cycle. Start hits are ignored.
  - A stop hit latches `stop_bin` and the counter value of that cycle, then moves to DONE.
  - If the counter equals `TIMEOUT_CYCLES` with no stop hit, move to DONE with `res_timeout`=1, `res_stop_bin`=0 and `res_coarse`=`TIMEOUT_CYCLES`.
  - A stop hit in the cycle the counter reaches `TIMEOUT_CYCLES` wins: it is a valid stop and `res_timeout`=0.
- **DONE:**
  - `res_valid`=1 and all result fields are held stable until `res_ready`.
  - On the handshake, move to ARMED if `continuous`=1, otherwise to IDLE.
  - `arm` is ignored.
  - Each start hit increments `missed_hits`, which saturates at 255.
- **abort:** has priority over every other input in every state. Next state is IDLE, `res_valid` drops the next cycle and the pending result is discarded.
- `arm` while busy is ignored and does not queue.
- The coarse counter never wraps, because of the `TIMEOUT_CYCLES` width constraint.

## Timing
- `arm` at cycle n → `busy`=1 at n+1. Hits are sampled from n+1.
- Start hit at cycle t, stop hit at cycle u > t → `res_coarse`=u−t and `res_valid`=1 at u+1.
- The result is registered: there is no combinational path from `start_bin`/`stop_bin` to the outputs.
- Handshake at cycle h (`res_valid`&`res_ready`):
  - `res_valid`=0 at h+1.
  - If `continuous`=1, a start hit at h+1 is accepted.
- Reset mid-measurement: IDLE at the next cycle, outputs 0, `missed_hits` cleared.

## Structure
- Shared package `tdc_pkg` holds:
  - the state enum `tdc_seq_state_t` (IDLE, ARMED, RUN, DONE);
  - the default `BITS_DECO`, so the decoders and the sequencer agree.
- One natural sub-module: `tdc_coarse_counter`, with clear, enable, count output and a terminal flag at `TIMEOUT_CYCLES`.
- The FSM, result registers and `missed_hits` live in the top.

## Test plan
- Arm, `start_bin`=17 at t, `stop_bin`=42 at t+5 → at t+6: `res_valid`=1, coarse=5, start=17, stop=42, timeout=0.
- `TIMEOUT_CYCLES`=8, start at t and no stop → DONE with coarse=8, `res_stop_bin`=0, timeout=1. Repeat with the stop exactly at t+8 → timeout=0, coarse=8.
- Start 3 and stop 9 in the same ARMED cycle → coarse=0 and both bins latched. A stop-only cycle in ARMED leaves the state ARMED.
- `res_ready` held 0 for 10 cycles while 3 start hits arrive → result fields stable and `missed_hits`=3. Then `res_ready`=1 with `continuous`=1 → ARMED, `busy` stays 1.
- `abort` during RUN, and separately during DONE → IDLE next cycle, `res_valid`=0, the next `arm` starts cleanly.
- `rst` pulsed during RUN → all outputs 0 and IDLE the next cycle. `arm` during DONE has no effect.
